// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_grant_arbiter_if;
    logic       arb_en;
    logic [3:0] req;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       grant_start;
    logic       timeout_pulse;

    modport master (
        output arb_en,
        output req,
        input  grant_idx,
        input  grant_valid,
        input  grant_start,
        input  timeout_pulse
    );

    modport slave (
        input  arb_en,
        input  req,
        output grant_idx,
        output grant_valid,
        output grant_start,
        output timeout_pulse
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Four-requester round-robin arbiter with registered grant outputs feeding the 2-to-4 select decoder.
// Optional hold-time limit with forced handoff is enabled by defining ARB_TIMEOUT_EN.
module rr_grant_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic              clk,
    input logic              rst_n,
    rr_grant_arbiter_if.slave bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : gen_bad_max_hold
        $error("MAX_HOLD must be in 2..255");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] grant_idx_q, grant_idx_d;
    logic [1:0] last_idx_q, last_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       grant_start_q, grant_start_d;
    logic       timeout_q, timeout_d;

    logic [3:0] masked_req;
    logic       win_found;
    logic [1:0] win_idx;
    logic       owner_release;
    logic       hold_expired;

    // Scan last+1 .. last+4 (mod 4); first set bit wins.
    function automatic logic [2:0] find_winner(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!res[2] && r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // While granted, the owner never wins a handoff search (release or revoke).
    always_comb begin
        masked_req = bus.req;
        if (state_q == StGrant) begin
            masked_req[grant_idx_q] = 1'b0;
        end
        {win_found, win_idx} = find_winner(masked_req, last_idx_q);
    end

    assign owner_release = (state_q == StGrant) && !bus.req[grant_idx_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;

    assign hold_expired = (state_q == StGrant) && (hold_cnt_q == HoldLast);

    always_comb begin
        hold_cnt_d = 8'd0;
        if (state_d == StGrant && !grant_start_d && !hold_expired) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            grant_idx_q   <= 2'b00;
            last_idx_q    <= 2'b11;
            grant_valid_q <= 1'b0;
            grant_start_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            last_idx_q    <= last_idx_d;
            grant_valid_q <= grant_valid_d;
            grant_start_q <= grant_start_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.arb_en && win_found) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!bus.arb_en) begin
                    state_d = StIdle;
                end else if (owner_release && !win_found) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // arb_en low outranks release, and release outranks a hold timeout.
    always_comb begin
        grant_idx_d   = grant_idx_q;
        last_idx_d    = last_idx_q;
        grant_valid_d = (state_d == StGrant);
        grant_start_d = 1'b0;
        timeout_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.arb_en && win_found) begin
                    grant_idx_d   = win_idx;
                    last_idx_d    = win_idx;
                    grant_start_d = 1'b1;
                end
            end
            StGrant: begin
                if (bus.arb_en && win_found && (owner_release || hold_expired)) begin
                    grant_idx_d   = win_idx;
                    last_idx_d    = win_idx;
                    grant_start_d = 1'b1;
                    timeout_d     = !owner_release;
                end
            end
            default: ;
        endcase
    end

    assign bus.grant_idx     = grant_idx_q;
    assign bus.grant_valid   = grant_valid_q;
    assign bus.grant_start   = grant_start_q;
    assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: vector table plus hand-written reset, rotation and
// hold-limit sequences (the latter only when ARB_TIMEOUT_EN is defined).
module tb_rr_grant_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rr_grant_arbiter_if bus ();

    rr_grant_arbiter #(
        .MAX_HOLD(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [3:0] req;
        logic       v;
        logic [1:0] idx;
        logic       s;
    } vec_t;

    vec_t vecs [23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic v, input logic [1:0] idx,
                         input logic s, input logic to);
        n_tests++;
        if (bus.grant_valid !== v || bus.grant_idx !== idx || bus.grant_start !== s ||
            bus.timeout_pulse !== to) begin
            n_fail++;
            $display("FAIL %s: got valid=%b idx=%0d start=%b tmo=%b, want valid=%b idx=%0d start=%b tmo=%b",
                     name, bus.grant_valid, bus.grant_idx, bus.grant_start, bus.timeout_pulse,
                     v, idx, s, to);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.arb_en = 1'b0;
        bus.req    = 4'b0000;

        //           en    req      v     idx   s
        vecs[0]  = '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        vecs[1]  = '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[4]  = '{1'b1, 4'b1111, 1'b1, 2'd1, 1'b1};
        vecs[5]  = '{1'b1, 4'b1111, 1'b1, 2'd1, 1'b0};
        vecs[6]  = '{1'b1, 4'b1101, 1'b1, 2'd2, 1'b1};
        vecs[7]  = '{1'b1, 4'b1111, 1'b1, 2'd2, 1'b0};
        vecs[8]  = '{1'b1, 4'b1011, 1'b1, 2'd3, 1'b1};
        vecs[9]  = '{1'b1, 4'b0111, 1'b1, 2'd0, 1'b1};
        vecs[10] = '{1'b1, 4'b0110, 1'b1, 2'd1, 1'b1};
        vecs[11] = '{1'b1, 4'b0101, 1'b1, 2'd2, 1'b1};
        vecs[12] = '{1'b1, 4'b0101, 1'b1, 2'd2, 1'b0};
        vecs[13] = '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b0};
        vecs[15] = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b0};
        vecs[16] = '{1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
        vecs[17] = '{1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[18] = '{1'b0, 4'b0010, 1'b0, 2'd1, 1'b0};
        vecs[19] = '{1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
        vecs[20] = '{1'b1, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[21] = '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
        vecs[22] = '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};

        tick();
        check("reset_state", 1'b0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            bus.arb_en = vecs[i].en;
            bus.req    = vecs[i].req;
            tick();
            check($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].s, 1'b0);
        end

        // Asynchronous reset in the middle of a grant to 3.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 2'd0, 1'b0, 1'b0);
        #1;
        rst_n   = 1'b1;
        bus.req = 4'b1001;
        tick();
        check("post_reset_prio0", 1'b1, 2'd0, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        check("post_reset_release", 1'b0, 2'd0, 1'b0, 1'b0);

        // Full rotation under constant contention, no bubble on handoff.
        do_reset();
        bus.req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            logic [1:0] owner;
            logic [3:0] drop;
            owner = 2'(k % 4);
            check($sformatf("rr_first%0d", k), 1'b1, owner, 1'b1, 1'b0);
            bus.req = 4'b1111;
            tick();
            check($sformatf("rr_hold%0d_a", k), 1'b1, owner, 1'b0, 1'b0);
            tick();
            check($sformatf("rr_hold%0d_b", k), 1'b1, owner, 1'b0, 1'b0);
            drop = 4'b1111;
            drop[owner] = 1'b0;
            bus.req = drop;
            tick();
        end
        check("rr_after_loop", 1'b1, 2'd1, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();

`ifdef ARB_TIMEOUT_EN
        do_reset();
        bus.req = 4'b0011;
        tick();
        check("to_first", 1'b1, 2'd0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("to_hold%0d", c), 1'b1, 2'd0, 1'b0, 1'b0);
        end
        tick();
        check("to_revoke", 1'b1, 2'd1, 1'b1, 1'b1);
        bus.req = 4'b0001;
        tick();
        check("to_back_to0", 1'b1, 2'd0, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("to_solo%0d", c), 1'b1, 2'd0, 1'b0, 1'b0);
        end
`else
        // Without the hold limit a contended owner keeps the grant indefinitely.
        do_reset();
        bus.req = 4'b0011;
        tick();
        check("hold_first", 1'b1, 2'd0, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("hold_forever%0d", c), 1'b1, 2'd0, 1'b0, 1'b0);
        end
`endif
        bus.req = 4'b0000;
        tick();
        check("final_idle", 1'b0, 2'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Four-requester round-robin arbiter that produces the registered grant index and grant-valid driving the gated 2-to-4 select decoder.
- Wiring to the decoder: grant_idx[0] feeds A, grant_idx[1] feeds B, grant_valid feeds Enable.
- It sits directly upstream of the decoder. The decoder then produces the one-hot select for the shared peripheral bus.
- Grants are held until the owner releases its request, with back-to-back handoff to the next requester.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one requester may hold the grant. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- arb_en  input  1  arbiter enable; low blocks and drops grants.
- req  input  4  request vector; bit i is requester i. Each requester holds its bit high for the whole transaction.
- grant_idx  output  2  index of the current owner; drives decoder {B,A}.
- grant_valid  output  1  grant active; drives decoder Enable.
- grant_start  output  1  one-cycle pulse in the first cycle of each new grant, including a handoff.
- timeout_pulse  output  1  one-cycle pulse when a grant is forcibly revoked. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant_idx=2'b00, grant_valid=0, grant_start=0, timeout_pulse=0, last_idx=2'b11. With last_idx=3, requester 0 has first priority.
- All outputs are registered; none combinationally depend on req.
- States: IDLE, GRANT.
- Winner search: scan indices last_idx+1, +2, +3, +4 modulo 4; the first index with req set wins. Index arithmetic is 2-bit and wraps 3 -> 0.
- IDLE, arb_en=1 and req!=0:
  - next edge: grant_valid=1, grant_idx=winner, last_idx=winner, grant_start=1, state=GRANT.
  - Latency: req sampled at edge N produces a grant visible after edge N.
- IDLE, req==0 or arb_en=0: stay; outputs unchanged, with grant_valid=0.
- GRANT, req[grant_idx]=1 and arb_en=1: hold; grant_start=0.
- GRANT, req[grant_idx]=0 (release):
  - The search excludes the releasing index.
  - If a winner exists: grant_idx=winner, last_idx=winner, grant_valid stays 1, grant_start=1. This is a zero-bubble handoff.
  - Else grant_valid=0, state=IDLE. grant_idx keeps its last value.
- GRANT, arb_en=0: next edge grant_valid=0, state=IDLE. last_idx is retained. arb_en has priority over release and timeout.
- Simultaneous release and new requests on the same edge: arbitration uses the req value sampled at that edge.
- The current owner re-requesting on the cycle after its release competes normally. It has lowest priority because last_idx equals its index.
- grant_idx changes only while grant_valid=1 (handoff) or on the IDLE -> GRANT transition. While grant_valid=0 the decoder output is all zero regardless of grant_idx.
- Reset mid-grant: outputs clear immediately and asynchronously. Arbitration restarts from priority 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on each grant_start and increments each GRANT cycle.
  - When the count reaches MAX_HOLD-1 and another request is pending, the next edge hands off to the winner (excluding the current owner), with grant_start=1 and timeout_pulse=1.
  - If no other request is pending, the grant continues and the counter clears; no pulse.
  - A revoked requester keeps its req high and re-enters arbitration at lowest priority.
- Undefined: no counter; grants are held indefinitely; timeout_pulse is constant 0.

Test Plan:
- Reset, then req=4'b0001 at edge 1 -> after edge 1: grant_valid=1, grant_idx=0, grant_start=1 for one cycle. Release req -> grant_valid=0 after the next edge.
- req=4'b1111 held, each owner releasing after 3 cycles and re-raising 1 cycle later -> grant order 0,1,2,3,0, with no bubble cycles (grant_valid stays 1).
- Owner 2 granted, req=4'b0101, owner 2 drops -> next edge grant_idx=0 (wrap from 2 past 3 to 0), grant_valid=1, grant_start=1.
- Grant held by 1, arb_en driven low -> next edge grant_valid=0. arb_en high with req=4'b0010 -> grant to 1 again.
- Assert rst_n=0 mid-cycle during a grant to 3 -> grant_valid=0, grant_idx=0 immediately. After release, req=4'b1001 -> grant_idx=0.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held -> grant 0 for 4 cycles, then timeout_pulse=1 with grant_idx=1. With req=4'b0001 only, grant 0 held indefinitely and timeout_pulse stays 0.
